flow_director_out_fifo: RTL and testbench
=========================================

// Module: flow_director_out_fifo
// PURPOSE
//  Elastic metadata buffer that decouples the flow director from the queue
//  manager / descriptor stage, which consumes metadata_t records. The flow
//  director sits directly upstream; the queue manager sits directly downstream.
//  Absorbs downstream stalls, exports occupancy and an almost-full flag, and can
//  optionally drop records when full instead of back-pressuring.
// PARAMETERS
//  DEPTH      16  entries; power of two, 4..1024
//  AW         $clog2(DEPTH)  pointer width (derived, not overridable)
// PORTS
//  clk                  in   1         core clock
//  rst_n                in   1         async reset, active-low
//  in_meta_data         in   metadata_t  record from flow director
//  in_meta_valid        in   1         record present
//  in_meta_ready        out  1         buffer accepts record
//  out_meta_data        out  metadata_t  record to queue manager
//  out_meta_valid       out  1         record present
//  out_meta_ready       in   1         downstream accepts
//  cfg_drop_when_full   in   1         1 = drop on full, 0 = back-pressure
//  cfg_almost_full_thr  in   AW+1      almost-full threshold (entries)
//  occupancy            out  AW+1      current entry count
//  almost_full          out  1         occupancy >= cfg_almost_full_thr
//  stat_accepted        out  32        records written (stats builds only)
//  stat_dropped         out  32        records dropped (stats builds only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): pointers=0, occupancy=0, out_meta_valid=0,
//    in_meta_ready=0 while asserted, almost_full=0, stats=0; out_meta_data
//    don't-care. First cycle after release: in_meta_ready=1.
//  - Reset mid-operation discards all stored records; no partial output.
//  - Handshake: transfer on valid&&ready at a clk edge. out_meta_valid, once
//    high, stays high and out_meta_data stays stable until out_meta_ready.
//  - Latency: record accepted at edge N -> out_meta_valid at edge N+1 when the
//    buffer was empty (registered output, no comb path in->out).
//  - in_meta_ready: !full when cfg_drop_when_full=0; constant 1 when
//    cfg_drop_when_full=1. Computed from registered state only; no comb path
//    from out_meta_ready.
//  - Full (occupancy==DEPTH) with drop mode: incoming valid record is consumed
//    and discarded; stat_dropped++. Full is evaluated before the same-cycle pop,
//    so push+pop when full in drop mode still drops the push.
//  - Simultaneous push and pop when not full and not empty: occupancy
//    unchanged; order strictly FIFO.
//  - Empty: out_meta_valid=0; push with empty buffer never bypasses the register.
//  - Pointers AW bits, wrap modulo DEPTH; occupancy is AW+1 bits, range 0..DEPTH.
//  - almost_full registered with occupancy; thr=0 -> always 1;
//    thr>DEPTH -> never 1.
//  - cfg_* inputs are sampled every cycle; changing cfg_drop_when_full never
//    corrupts or reorders stored records.
// CONFIGURATION
//  - Macro FLOW_DIRECTOR_OUT_FIFO_STATS_EN.
//  - Defined: stat_accepted increments on each write into storage; stat_dropped
//    increments on each drop. Both saturate at 32'hFFFF_FFFF. Both clear on reset.
//  - Undefined: both counters are tied to 0 and no counter flops exist. Data-path
//    behaviour is identical in both builds.
// TESTING
//  - Reset release, DEPTH=16: 20 records back-to-back, out_meta_ready=1 ->
//    20 records out in order; first one a single cycle after its accept;
//    occupancy <= 1.
//  - out_meta_ready=0, backpressure mode: push 17 -> ready drops after 16th;
//    occupancy=16; 17th held upstream until one pop, then enters in order.
//  - Drop mode, full, out_meta_ready=0: push 5 more -> ready stays 1;
//    stat_dropped=5 (stats build); first 16 records emerge intact.
//  - thr=12: fill 0->16 -> almost_full rises the cycle occupancy reaches 12;
//    falls when it reaches 11.
//  - Hold out_meta_ready low 10 cycles with valid high -> out_meta_data stable
//    and valid held; then continuous push+pop at occupancy 8 -> occupancy stays 8.
//  - Assert rst_n=0 asynchronously with 9 entries -> occupancy=0 and
//    out_meta_valid=0 immediately; after release the next push emerges first.

Source files
------------

// File: rtl/flow_director_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | flow_director_out_fifo                                                     |
// | Elastic metadata FIFO between flow director and queue manager, with        |
// | occupancy, almost-full flag and optional drop-on-full mode.                |
// | Optional counters: define FLOW_DIRECTOR_OUT_FIFO_STATS_EN.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module flow_director_out_fifo #(
  parameter int DEPTH  = 16,
  parameter int META_W = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [META_W-1:0] in_meta_data,
  input  logic              in_meta_valid,
  output logic              in_meta_ready,
  output logic [META_W-1:0] out_meta_data,
  output logic              out_meta_valid,
  input  logic              out_meta_ready,
  input  logic              cfg_drop_when_full,
  input  logic [AW:0]       cfg_almost_full_thr,
  output logic [AW:0]       occupancy,
  output logic              almost_full,
  output logic [31:0]       stat_accepted,
  output logic [31:0]       stat_dropped
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [META_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              rdy_q;
  logic              af_q;
  logic              full;
  logic              push_req;
  logic              wr_en;
  logic              pop;

  // Full is judged on the registered count, before any same-cycle pop.
  assign full           = (count_q == C_DEPTH);
  assign in_meta_ready  = rdy_q & (cfg_drop_when_full | ~full);
  assign push_req       = in_meta_valid & in_meta_ready;
  assign wr_en          = push_req & ~full;
  assign out_meta_valid = (count_q != '0);
  assign pop            = out_meta_valid & out_meta_ready;
  assign out_meta_data  = mem_q[rd_ptr_q];
  assign occupancy      = count_q;
  assign almost_full    = af_q;

  always_comb begin
    count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
      af_q     <= 1'b0;
    end else begin
      rdy_q   <= 1'b1;
      count_q <= count_d;
      af_q    <= (count_d >= cfg_almost_full_thr);
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage holds don't-care data after reset, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_meta_data;
  end

`ifdef FLOW_DIRECTOR_OUT_FIFO_STATS_EN
  logic        drop;
  logic [31:0] acc_q, drp_q;

  assign drop = push_req & full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      drp_q <= '0;
    end else begin
      if (wr_en && acc_q != 32'hFFFF_FFFF) acc_q <= acc_q + 32'd1;
      if (drop  && drp_q != 32'hFFFF_FFFF) drp_q <= drp_q + 32'd1;
    end
  end

  assign stat_accepted = acc_q;
  assign stat_dropped  = drp_q;
`else
  assign stat_accepted = '0;
  assign stat_dropped  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flow_director_out_fifo.sv
`default_nettype none
// Directed self-checking bench for flow_director_out_fifo (DEPTH=16).
module tb_flow_director_out_fifo;

  localparam int DEPTH = 16;
  localparam int MW    = 32;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [MW-1:0] in_meta_data;
  logic          in_meta_valid;
  logic          in_meta_ready;
  logic [MW-1:0] out_meta_data;
  logic          out_meta_valid;
  logic          out_meta_ready;
  logic          cfg_drop_when_full;
  logic [AW:0]   cfg_almost_full_thr;
  logic [AW:0]   occupancy;
  logic          almost_full;
  logic [31:0]   stat_accepted;
  logic [31:0]   stat_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  logic [MW-1:0] exp_q[$];
  int  mcnt    = 0;
  int  occ_max = 0;
  bit  mon_en  = 0;
  bit  af_en   = 1;

  always #5 clk = ~clk;

  flow_director_out_fifo #(.DEPTH(DEPTH), .META_W(MW)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .in_meta_data        (in_meta_data),
    .in_meta_valid       (in_meta_valid),
    .in_meta_ready       (in_meta_ready),
    .out_meta_data       (out_meta_data),
    .out_meta_valid      (out_meta_valid),
    .out_meta_ready      (out_meta_ready),
    .cfg_drop_when_full  (cfg_drop_when_full),
    .cfg_almost_full_thr (cfg_almost_full_thr),
    .occupancy           (occupancy),
    .almost_full         (almost_full),
    .stat_accepted       (stat_accepted),
    .stat_dropped        (stat_dropped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    out_meta_ready = 1'b1;
    in_meta_valid  = 1'b0;
    k = 0;
    while (occupancy != 0 && k < 100) begin
      step();
      k++;
    end
    chk("drain_done", {27'd0, occupancy}, 32'd0);
    out_meta_ready = 1'b0;
  endtask

  // Reference model: tracks expected count and order; sampled mid-cycle,
  // where the values seen are the ones the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt = 0;
      exp_q.delete();
    end else if (mon_en) begin
      bit acc;
      bit pp;
      chk("mon_occ", {27'd0, occupancy}, mcnt);
      chk("mon_valid", {31'd0, out_meta_valid}, {31'd0, (mcnt != 0)});
      if (af_en)
        chk("mon_af", {31'd0, almost_full}, {31'd0, (mcnt >= int'(cfg_almost_full_thr))});
      if (mcnt > occ_max) occ_max = mcnt;
      acc = in_meta_valid && in_meta_ready && (mcnt < DEPTH);
      pp  = out_meta_valid && out_meta_ready;
      if (pp) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
        else chk("pop_data", out_meta_data, exp_q.pop_front());
      end
      if (acc) exp_q.push_back(in_meta_data);
      mcnt = mcnt + int'(acc) - int'(pp);
    end
  end

  initial begin
    logic [MW-1:0] held;
    logic [31:0]   exp_acc, exp_drp;

    rst_n = 1'b0;
    in_meta_data = '0;
    in_meta_valid = 1'b0;
    out_meta_ready = 1'b0;
    cfg_drop_when_full = 1'b0;
    cfg_almost_full_thr = 5'd12;
    repeat (3) step();
    chk("rst_occ", {27'd0, occupancy}, 32'd0);
    chk("rst_valid", {31'd0, out_meta_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_meta_ready}, 32'd0);
    chk("rst_af", {31'd0, almost_full}, 32'd0);
    chk("rst_stat_acc", stat_accepted, 32'd0);
    chk("rst_stat_drp", stat_dropped, 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, in_meta_ready}, 32'd1);

    // 20 back-to-back records with a free-flowing sink
    out_meta_ready = 1'b1;
    occ_max = 0;
    for (int i = 0; i < 20; i++) begin
      in_meta_valid = 1'b1;
      in_meta_data  = 32'h100 + i;
      step();
      if (i == 0) chk("first_latency_valid", {31'd0, out_meta_valid}, 32'd1);
    end
    in_meta_valid = 1'b0;
    drain();
    chk("stream_occ_max", occ_max, 32'd1);

    // back-pressure: 17 pushes into a stalled sink
    out_meta_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_meta_valid = 1'b1;
      in_meta_data  = 32'h200 + i;
      step();
    end
    chk("bp_occ16", {27'd0, occupancy}, 32'd16);
    chk("bp_ready0", {31'd0, in_meta_ready}, 32'd0);
    in_meta_data = 32'h210;
    repeat (3) step();
    chk("bp_hold_ready0", {31'd0, in_meta_ready}, 32'd0);
    chk("bp_hold_occ", {27'd0, occupancy}, 32'd16);
    out_meta_ready = 1'b1;
    step();
    out_meta_ready = 1'b0;
    chk("bp_after_pop_ready", {31'd0, in_meta_ready}, 32'd1);
    step();
    in_meta_valid = 1'b0;
    chk("bp_17th_in", {27'd0, occupancy}, 32'd16);

    // drop mode while full
    cfg_drop_when_full = 1'b1;
    #1;
    chk("drop_ready1", {31'd0, in_meta_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_meta_valid = 1'b1;
      in_meta_data  = 32'h300 + i;
      step();
      chk("drop_ready_stay", {31'd0, in_meta_ready}, 32'd1);
    end
    in_meta_valid = 1'b0;
    chk("drop_occ", {27'd0, occupancy}, 32'd16);
`ifdef FLOW_DIRECTOR_OUT_FIFO_STATS_EN
    exp_drp = 32'd5;
    exp_acc = 32'd37;
`else
    exp_drp = 32'd0;
    exp_acc = 32'd0;
`endif
    chk("stat_dropped", stat_dropped, exp_drp);
    chk("stat_accepted", stat_accepted, exp_acc);
    cfg_drop_when_full = 1'b0;
    drain();

    // almost-full threshold 12: fill to 16, then unwind to 8
    for (int i = 0; i < 16; i++) begin
      in_meta_valid = 1'b1;
      in_meta_data  = 32'h400 + i;
      step();
      chk("af_fill", {31'd0, almost_full}, {31'd0, (i + 1 >= 12)});
    end
    in_meta_valid  = 1'b0;
    out_meta_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("af_unwind", {31'd0, almost_full}, {31'd0, (16 - j >= 12)});
    end
    out_meta_ready = 1'b0;
    chk("occ8", {27'd0, occupancy}, 32'd8);

    // stalled output holds data and valid
    held = exp_q[0];
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_valid", {31'd0, out_meta_valid}, 32'd1);
      chk("stall_data", out_meta_data, held);
    end

    // continuous push+pop at occupancy 8
    out_meta_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_meta_valid = 1'b1;
      in_meta_data  = 32'h500 + k;
      step();
      chk("pushpop_occ8", {27'd0, occupancy}, 32'd8);
    end
    out_meta_ready = 1'b0;
    in_meta_data   = 32'h5FF;
    step();
    in_meta_valid = 1'b0;
    chk("occ9", {27'd0, occupancy}, 32'd9);

    // asynchronous reset with 9 entries stored
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_occ", {27'd0, occupancy}, 32'd0);
    chk("async_rst_valid", {31'd0, out_meta_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, in_meta_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("rerst_ready", {31'd0, in_meta_ready}, 32'd1);
    in_meta_valid = 1'b1;
    in_meta_data  = 32'h600;
    step();
    in_meta_valid = 1'b0;
    chk("rerst_valid", {31'd0, out_meta_valid}, 32'd1);
    chk("rerst_first", out_meta_data, 32'h600);
`ifdef FLOW_DIRECTOR_OUT_FIFO_STATS_EN
    exp_acc = 32'd1;
`else
    exp_acc = 32'd0;
`endif
    chk("rerst_stat_acc", stat_accepted, exp_acc);
    drain();

    // threshold extremes
    af_en = 1'b0;
    cfg_almost_full_thr = 5'd0;
    step();
    chk("thr0_af", {31'd0, almost_full}, 32'd1);
    cfg_almost_full_thr = 5'd17;
    for (int i = 0; i < 16; i++) begin
      in_meta_valid = 1'b1;
      in_meta_data  = 32'h700 + i;
      step();
    end
    in_meta_valid = 1'b0;
    step();
    chk("thr17_full_occ", {27'd0, occupancy}, 32'd16);
    chk("thr17_af", {31'd0, almost_full}, 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
